conv_kxk_mc: RTL and testbench

- Parametrised successor to the fixed 6-channel 5x5 convolution-sum block.
- Computes one output-feature-map pixel as sum over CH input channels of (KxK window · KxK filter), plus a scaled bias, with optional ReLU and output saturation.
- Channels arrive serially, one window per accepted beat, so one multiplier array is shared across channels.
- Sits between the window line-buffer generator and the pooling stage of the conv layers.

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/dot_kxk.sv | 47 ++++
 rtl/conv_kxk_mc.sv | 179 +++++++++++++++++
 tb/tb_conv_kxk_mc.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the convolution / fully-connected blocks: width
// arithmetic and a generic signed saturation used by every result stage.
package conv_pkg;

    // Width of the scratch vector used by sat_to; callers keep their
    // accumulators at or below this width.
    localparam int SAT_W = 128;

    // $clog2 that never returns less than one bit, for index and growth fields.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Accumulator width that holds CH*K*K full-precision products plus a
    // shifted bias without overflow, with two guard bits.
    function automatic int acc_width(input int bw, input int k, input int ch, input int shift);
        return 2 * bw + $clog2(ch * k * k) + shift + 2;
    endfunction

    // Clamp a signed value into the signed range of 'width' bits.  The result
    // is still SAT_W bits wide; the caller keeps the low 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                       input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        if (width >= SAT_W) begin
            return v;
        end
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/dot_kxk.sv
// Combinational K*K signed dot product: per-tap full-precision multiply
// followed by a balanced binary adder tree, sign-extended to OUT_W.
module dot_kxk
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int K         = 5,
    parameter int OUT_W     = 2 * BIT_WIDTH + clog2_min1(K * K)
) (
    input  logic [K*K*BIT_WIDTH-1:0] win,
    input  logic [K*K*BIT_WIDTH-1:0] filt,
    output logic signed [OUT_W-1:0]  dot
);

    localparam int TAPS  = K * K;
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int NODES = 2 * TAPS - 1;

    // Heap-ordered tree: leaves sit at TAPS-1 .. 2*TAPS-2, node i sums its
    // children 2i+1 and 2i+2, so node 0 is the total for any tap count.
    logic signed [OUT_W-1:0] node_s [NODES];

    // Build the products at the leaves, then fold the tree from the bottom up.
    always_comb begin
        logic signed [BIT_WIDTH-1:0] w_e;
        logic signed [BIT_WIDTH-1:0] f_e;
        logic signed [PW-1:0]        p_e;
        w_e = '0;
        f_e = '0;
        p_e = '0;
        for (int n = 0; n < NODES; n++) begin
            node_s[n] = '0;
        end
        for (int i = 0; i < TAPS; i++) begin
            w_e = win[i*BIT_WIDTH +: BIT_WIDTH];
            f_e = filt[i*BIT_WIDTH +: BIT_WIDTH];
            p_e = PW'(w_e) * PW'(f_e);
            node_s[TAPS-1+i] = OUT_W'(p_e);
        end
        for (int n = TAPS - 2; n >= 0; n--) begin
            node_s[n] = node_s[2*n+1] + node_s[2*n+2];
        end
    end

    assign dot = node_s[0];

endmodule

// File: rtl/conv_kxk_mc.sv
// Multi-channel KxK convolution sum for one output pixel.  Channel windows
// arrive serially; stage 1 registers the per-channel dot product, stage 2
// accumulates across channels and, on the last channel, adds the scaled bias,
// applies optional ReLU and saturates into the output register.
module conv_kxk_mc
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int K          = 5,
    parameter int CH         = 6,
    parameter int BIAS_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         relu_en,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [K*K*BIT_WIDTH-1:0]     win,
    input  logic [CH*K*K*BIT_WIDTH-1:0]  filter,
    input  logic [BIT_WIDTH-1:0]         bias,
    output logic [$clog2(CH):0]          ch_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data
);

    localparam int ACC_W    = acc_width(BIT_WIDTH, K, CH, BIAS_SHIFT);
    localparam int CIW      = $clog2(CH) + 1;
    localparam int TAP_BITS = K * K * BIT_WIDTH;
    localparam logic [CIW-1:0] LAST_CH = CIW'(CH - 1);

    // Channel counter: authoritative index of the next beat.
    logic [CIW-1:0]          ch_idx_q, ch_idx_d;

    // Stage 1: registered per-channel dot product and its frame position.
    logic signed [ACC_W-1:0] prod_q, prod_d;
    logic                    prod_v_q, prod_v_d;
    logic                    prod_first_q, prod_first_d;
    logic                    prod_last_q, prod_last_d;

    // Stage 2: running channel sum and the output holding register.
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;

    // Combinational helpers.
    logic [TAP_BITS-1:0]     filt_sel_s;
    logic signed [ACC_W-1:0] dot_s;
    logic                    adv2_s;
    logic                    in_rdy_s;
    logic                    accept_s;
    logic                    fire_s;
    logic signed [ACC_W-1:0] acc_base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] t_s;
    logic signed [ACC_W-1:0] t_relu_s;
    logic [OUT_WIDTH-1:0]    res_s;

    // Select the filter slice belonging to the channel expected next.
    always_comb begin
        filt_sel_s = filter[TAP_BITS-1:0];
        for (int c = 1; c < CH; c++) begin
            filt_sel_s = (ch_idx_q == CIW'(c)) ? filter[c*TAP_BITS +: TAP_BITS] : filt_sel_s;
        end
    end

    dot_kxk #(
        .BIT_WIDTH (BIT_WIDTH),
        .K         (K),
        .OUT_W     (ACC_W)
    ) u_dot (
        .win  (win),
        .filt (filt_sel_s),
        .dot  (dot_s)
    );

    // Handshakes: stage 2 only stalls when a finished pixel would overwrite an
    // undelivered one; stage 1 accepts whenever it is empty or draining.
    always_comb begin
        adv2_s   = !(prod_v_q && prod_last_q && out_valid_q && !out_ready);
        in_rdy_s = !prod_v_q || adv2_s;
        accept_s = in_valid && in_rdy_s && !clear;
        fire_s   = prod_v_q && adv2_s && !clear;
    end

    assign in_ready = in_rdy_s;

    // Result path: accumulate, add the shifted bias, ReLU, then saturate.
    always_comb begin
        acc_base_s = prod_first_q ? '0 : acc_q;
        sum_s      = acc_base_s + prod_q;
        bias_ext_s = ACC_W'($signed(bias)) <<< BIAS_SHIFT;
        t_s        = sum_s + bias_ext_s;
        if (relu_en && t_s[ACC_W-1]) begin
            t_relu_s = '0;
        end else begin
            t_relu_s = t_s;
        end
        res_s = OUT_WIDTH'(sat_to(SAT_W'(t_relu_s), OUT_WIDTH));
    end

    // Stage-1 next state: clear drops the in-flight beat and rewinds the
    // counter; otherwise a beat loads or the stage empties into stage 2.
    always_comb begin
        ch_idx_d     = ch_idx_q;
        prod_d       = prod_q;
        prod_v_d     = prod_v_q;
        prod_first_d = prod_first_q;
        prod_last_d  = prod_last_q;
        if (clear) begin
            ch_idx_d = '0;
            prod_v_d = 1'b0;
        end else if (accept_s) begin
            prod_d       = dot_s;
            prod_v_d     = 1'b1;
            prod_first_d = (ch_idx_q == '0);
            prod_last_d  = (ch_idx_q == LAST_CH);
            ch_idx_d     = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + CIW'(1);
        end else if (fire_s) begin
            prod_v_d = 1'b0;
        end else begin
            prod_v_d = prod_v_q;
        end
    end

    // Stage-2 next state: a new pixel may replace one being accepted in the
    // same cycle; otherwise an accepted pixel retires and a held one stays.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (fire_s) begin
            acc_d = sum_s;
            if (prod_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = res_s;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_idx_q     <= '0;
            prod_q       <= '0;
            prod_v_q     <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            ch_idx_q     <= ch_idx_d;
            prod_q       <= prod_d;
            prod_v_q     <= prod_v_d;
            prod_first_q <= prod_first_d;
            prod_last_q  <= prod_last_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign ch_idx    = ch_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_kxk_mc.sv
// Bench for conv_kxk_mc: three instances share the input stream (default,
// 16-bit output, bias shift 4).  Directed table vectors and multi-cycle
// sequences, then randomized frames against a frame-level reference model.
module tb_conv_kxk_mc;

    localparam int BW   = 8;
    localparam int K    = 5;
    localparam int CH   = 6;
    localparam int TAPS = K * K;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clear = 1'b0;
    logic                    relu_en = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic [TAPS*BW-1:0]      win = '0;
    logic [CH*TAPS*BW-1:0]   filter = '0;
    logic [BW-1:0]           bias = '0;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic [3:0]  ch_idx_a, ch_idx_b, ch_idx_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a;
    logic [15:0] out_data_b;
    logic [31:0] out_data_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_kxk_mc #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .K(K), .CH(CH), .BIAS_SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready_a), .win(win), .filter(filter), .bias(bias), .ch_idx(ch_idx_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a));

    conv_kxk_mc #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .K(K), .CH(CH), .BIAS_SHIFT(0)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready_b), .win(win), .filter(filter), .bias(bias), .ch_idx(ch_idx_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b));

    conv_kxk_mc #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .K(K), .CH(CH), .BIAS_SHIFT(4)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en), .in_valid(in_valid),
        .in_ready(in_ready_c), .win(win), .filter(filter), .bias(bias), .ch_idx(ch_idx_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c));

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Snapshots taken just before each active edge.
    logic   fired_in, fired_out, snap_valid, snap_ir;
    longint snap_a, snap_b, snap_c;
    longint delivered[$];

    // One clock cycle: inputs are already set at the falling edge.
    task automatic cycle();
        #1;
        fired_in   = in_valid && in_ready_a && !clear;
        fired_out  = out_valid_a && out_ready;
        snap_valid = out_valid_a;
        snap_ir    = in_ready_a;
        snap_a     = longint'($signed(out_data_a));
        snap_b     = longint'($signed(out_data_b));
        snap_c     = longint'($signed(out_data_c));
        @(posedge clk);
        if (fired_out) delivered.push_back(snap_a);
        @(negedge clk);
    endtask

    task automatic set_win_all(input int v);
        for (int i = 0; i < TAPS; i++) win[i*BW +: BW] = v[BW-1:0];
    endtask

    task automatic set_filter_all(input int v);
        for (int i = 0; i < CH * TAPS; i++) filter[i*BW +: BW] = v[BW-1:0];
    endtask

    task automatic send_beats(input int n, input int wv);
        int got;
        int guard;
        got = 0;
        guard = 0;
        set_win_all(wv);
        in_valid = 1'b1;
        while (got < n && guard < 100) begin
            cycle();
            if (fired_in) got++;
            guard++;
        end
        in_valid = 1'b0;
        chk("beats_accepted", got, n);
    endtask

    task automatic send_frame(input int wv, input int fv, input int b, input bit r);
        set_filter_all(fv);
        bias    = b[BW-1:0];
        relu_en = r;
        send_beats(CH, wv);
    endtask

    // ---------------- reference model ----------------
    function automatic longint dot_model(input logic [TAPS*BW-1:0] w,
                                         input logic [CH*TAPS*BW-1:0] f, input int ch);
        longint s;
        logic signed [BW-1:0] a;
        logic signed [BW-1:0] b;
        s = 0;
        for (int i = 0; i < TAPS; i++) begin
            a = w[i*BW +: BW];
            b = f[(ch*TAPS+i)*BW +: BW];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic longint model_out(input longint s, input longint bv, input bit r,
                                         input int shift, input int ow);
        longint t;
        longint hi;
        t  = s + bv * (longint'(1) << shift);
        if (r && t < 0) t = 0;
        hi = (longint'(1) << (ow - 1)) - 1;
        if (t > hi) t = hi;
        if (t < -hi - 1) t = -hi - 1;
        return t;
    endfunction

    longint qa[$], qb[$], qc[$];
    int     model_ch = 0;
    longint partial = 0;
    longint cur_bias = 0;
    bit     cur_relu = 1'b0;

    task automatic handle_out();
        if (fired_out) begin
            chk("sb_has_entry", qa.size() > 0, 1);
            if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
                chk("rand_out_a", snap_a, qa.pop_front());
                chk("rand_out_b", snap_b, qb.pop_front());
                chk("rand_out_c", snap_c, qc.pop_front());
            end
        end
    endtask

    typedef struct {
        int     wv;
        int     fv;
        int     b;
        bit     r;
        longint ea;
        longint eb;
        longint ec;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit     prev_hold;
        longint prev_data;
        int     sent;
        int     hold;
        bit     seen_valid;
        bit     or_was;
        int     sent_before;
        int     guard;

        vecs[0]  = '{1, 1, 0, 1'b0, 150, 150, 150};
        vecs[1]  = '{127, -128, 0, 1'b0, -2438400, -32768, -2438400};
        vecs[2]  = '{127, -128, 0, 1'b1, 0, 0, 0};
        vecs[3]  = '{127, 127, 0, 1'b0, 2419350, 32767, 2419350};
        vecs[4]  = '{0, 1, -3, 1'b0, -3, -3, -48};
        vecs[5]  = '{0, 1, -3, 1'b1, 0, 0, 0};
        vecs[6]  = '{0, 1, 5, 1'b0, 5, 5, 80};
        vecs[7]  = '{2, 1, 0, 1'b0, 300, 300, 300};
        vecs[8]  = '{-1, 3, 7, 1'b0, -443, -443, -338};
        vecs[9]  = '{-1, 3, 7, 1'b1, 0, 0, 0};
        vecs[10] = '{100, 100, -128, 1'b0, 1499872, 32767, 1497952};

        // ---- reset state ----
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", longint'($signed(out_data_a)), 0);
        chk("rst_ch_idx", ch_idx_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        @(negedge clk);

        // ---- table-driven frames with latency check ----
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send_frame(vecs[i].wv, vecs[i].fv, vecs[i].b, vecs[i].r);
            chk($sformatf("tbl%0d_not_yet", i), out_valid_a, 0);
            cycle();
            chk($sformatf("tbl%0d_valid", i), out_valid_a, 1);
            chk($sformatf("tbl%0d_a", i), longint'($signed(out_data_a)), vecs[i].ea);
            chk($sformatf("tbl%0d_b", i), longint'($signed(out_data_b)), vecs[i].eb);
            chk($sformatf("tbl%0d_c", i), longint'($signed(out_data_c)), vecs[i].ec);
            chk($sformatf("tbl%0d_ch_idx", i), ch_idx_a, 0);
            cycle();
            cycle();
        end

        // ---- backpressure: frames 150 then 300, output stalled ----
        delivered.delete();
        set_filter_all(1);
        bias = '0;
        relu_en = 1'b0;
        out_ready = 1'b1;
        sent = 0;
        hold = 0;
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 12 || delivered.size() < 2); cyc++) begin
            set_win_all(sent < 6 ? 1 : 2);
            in_valid = (sent < 12);
            if (out_valid_a && !seen_valid) begin
                seen_valid = 1'b1;
                hold = 8;
            end
            out_ready = (hold > 0) ? 1'b0 : 1'b1;
            if (hold > 0) begin
                chk("bp_hold_valid", out_valid_a, 1);
                chk("bp_hold_data", longint'($signed(out_data_a)), 150);
                hold--;
            end
            or_was = out_ready;
            sent_before = sent;
            cycle();
            if (sent_before == 12 && !or_was) chk("bp_in_ready_low", snap_ir, 0);
            if (fired_in) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", sent, 12);
        chk("bp_delivered_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("bp_first", delivered[0], 150);
            chk("bp_second", delivered[1], 300);
        end
        cycle();
        cycle();

        // ---- reset mid-frame with a pending result ----
        out_ready = 1'b0;
        send_frame(1, 1, 0, 1'b0);
        cycle();
        chk("rstm_pending", longint'($signed(out_data_a)), 150);
        send_beats(3, 5);
        #2 rst = 1'b0;
        #1;
        chk("rstm_valid0", out_valid_a, 0);
        chk("rstm_data0", longint'($signed(out_data_a)), 0);
        chk("rstm_ch0", ch_idx_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        send_frame(2, 1, 0, 1'b0);
        cycle();
        chk("rstm_valid", out_valid_a, 1);
        chk("rstm_result", longint'($signed(out_data_a)), 300);
        cycle();
        cycle();

        // ---- clear mid-frame, pending result preserved ----
        out_ready = 1'b0;
        send_frame(2, 1, 0, 1'b0);
        cycle();
        send_beats(2, 3);
        clear = 1'b1;
        in_valid = 1'b1;
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_ch_idx", ch_idx_a, 0);
        chk("clr_pending_valid", out_valid_a, 1);
        chk("clr_pending_data", longint'($signed(out_data_a)), 300);
        send_frame(1, 1, 0, 1'b0);
        chk("clr_still_pending", longint'($signed(out_data_a)), 300);
        delivered.delete();
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("clr_delivered_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("clr_first", delivered[0], 300);
            chk("clr_second", delivered[1], 150);
        end

        // ---- randomized frames against the reference model ----
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        for (int i = 0; i < CH * TAPS; i++) filter[i*BW +: BW] = BW'($urandom);
        prev_hold = 1'b0;
        prev_data = 0;
        for (int n = 0; n < 700; n++) begin
            if (prev_hold) begin
                chk("rand_stable_valid", out_valid_a, 1);
                chk("rand_stable_data", longint'($signed(out_data_a)), prev_data);
            end
            chk("rand_ch_idx", ch_idx_a, model_ch);
            in_valid = ($urandom_range(3) != 0);
            for (int i = 0; i < TAPS; i++) win[i*BW +: BW] = BW'($urandom);
            out_ready = ($urandom_range(9) < 7);
            cycle();
            prev_hold = snap_valid && !out_ready;
            prev_data = snap_a;
            handle_out();
            if (fired_in) begin
                partial += dot_model(win, filter, model_ch);
                if (model_ch == 0) begin
                    bias     = BW'($urandom);
                    relu_en  = $urandom_range(1) == 1;
                    cur_bias = longint'($signed(bias));
                    cur_relu = relu_en;
                end
                if (model_ch == CH - 1) begin
                    qa.push_back(model_out(partial, cur_bias, cur_relu, 0, 32));
                    qb.push_back(model_out(partial, cur_bias, cur_relu, 0, 16));
                    qc.push_back(model_out(partial, cur_bias, cur_relu, 4, 32));
                    partial = 0;
                    model_ch = 0;
                    for (int i = 0; i < CH * TAPS; i++) filter[i*BW +: BW] = BW'($urandom);
                end else begin
                    model_ch++;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (qa.size() > 0 && guard < 40) begin
            cycle();
            handle_out();
            guard++;
        end
        chk("rand_drained", qa.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
